// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT two-layer sequencer.
// Holds the state encoding, the SWITCH_GAP bounds and the gap-load helper.
package gat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONV1 = 3'd1,
    ST_GAP   = 3'd2,
    ST_CONV2 = 3'd3,
    ST_DONE  = 3'd4
  } gat_state_e;

  localparam int unsigned GAP_MIN   = 1;
  localparam int unsigned GAP_MAX   = 15;
  localparam int unsigned GAP_CNT_W = 4;

  // Gap counter preload; an out-of-range gap is clamped into bounds.
  function automatic logic [GAP_CNT_W-1:0] gap_load(
    input int unsigned gap
  );
    int unsigned g;
    g = gap;
    if (g < GAP_MIN) g = GAP_MIN;
    if (g > GAP_MAX) g = GAP_MAX;
    return GAP_CNT_W'(g - 1);
  endfunction

endpackage

// File: rtl/gat_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Holds at all-ones until cleared.
module gat_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gat_layer_sequencer.sv
// Sequences conv1 -> gap -> conv2 for one GAT inference run.
// Optional per-layer cycle counters: define GAT_SEQ_PERF_CNT_EN.
module gat_layer_sequencer
  import gat_pkg::*;
#(
  parameter int unsigned SWITCH_GAP = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 h_data_bram_load_done,
  input  logic                 h_node_info_bram_load_done,
  input  logic                 wgt_bram_load_done,
  input  logic                 gat_start,
  input  logic                 gat_clr,
  input  logic                 conv1_done,
  input  logic                 conv2_done,
  output logic                 gat_layer,
  output logic                 conv1_start,
  output logic                 conv2_start,
  output logic                 gat_busy,
  output logic                 gat_done,
  output logic [2:0]           gat_state,
  output logic [CNT_WIDTH-1:0] conv1_cycles,
  output logic [CNT_WIDTH-1:0] conv2_cycles
);

  localparam logic [GAP_CNT_W-1:0] GapLoad = gap_load(SWITCH_GAP);

  gat_state_e           state_q, state_d;
  logic [2:0]           flags_q, flags_d;
  logic [2:0]           loads;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic                 layer_q, layer_d;
  logic                 c1s_q, c1s_d;
  logic                 c2s_q, c2s_d;
  logic                 clr_flags;

  assign loads = {wgt_bram_load_done,
                  h_node_info_bram_load_done,
                  h_data_bram_load_done};

  // A load pulse in the start cycle itself counts toward the start.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    layer_d   = layer_q;
    clr_flags = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gat_start && (&(flags_q | loads))) state_d = ST_CONV1;
      end
      ST_CONV1: begin
        if (conv1_done && !c1s_q) begin
          state_d = ST_GAP;
          gap_d   = GapLoad;
          layer_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_CONV2;
        else             gap_d   = gap_q - GAP_CNT_W'(1);
      end
      ST_CONV2: begin
        if (conv2_done && !c2s_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (gat_clr) begin
          state_d   = ST_IDLE;
          layer_d   = 1'b0;
          clr_flags = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    flags_d = (clr_flags ? 3'b000 : flags_q) | loads;
    c1s_d   = (state_q == ST_IDLE) && (state_d == ST_CONV1);
    c2s_d   = (state_q == ST_GAP) && (state_d == ST_CONV2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      flags_q <= '0;
      gap_q   <= '0;
      layer_q <= 1'b0;
      c1s_q   <= 1'b0;
      c2s_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      gap_q   <= gap_d;
      layer_q <= layer_d;
      c1s_q   <= c1s_d;
      c2s_q   <= c2s_d;
    end
  end

  assign gat_layer   = layer_q;
  assign conv1_start = c1s_q;
  assign conv2_start = c2s_q;
  assign gat_state   = state_q;
  assign gat_done    = (state_q == ST_DONE);
  assign gat_busy    = (state_q == ST_CONV1) ||
                       (state_q == ST_GAP) ||
                       (state_q == ST_CONV2);

`ifdef GAT_SEQ_PERF_CNT_EN
  // Cleared in the start cycle, so a layer done N cycles later reads N.
  gat_sat_counter #(
    .W(CNT_WIDTH)
  ) u_conv1_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(c1s_q),
    .en_i (state_q == ST_CONV1),
    .cnt_o(conv1_cycles)
  );

  gat_sat_counter #(
    .W(CNT_WIDTH)
  ) u_conv2_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(c2s_q),
    .en_i (state_q == ST_CONV2),
    .cnt_o(conv2_cycles)
  );
`else
  assign conv1_cycles = '0;
  assign conv2_cycles = '0;
`endif

endmodule

// File: tb/tb_gat_layer_sequencer.sv
// Directed bench for gat_layer_sequencer: one full run, ignored pulses,
// clear, set-wins, counters (32-bit and 4-bit instances) and mid-run reset.
module tb_gat_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_h, ld_n, ld_w;
  logic        start, clr, c1d, c2d;

  logic        layer, c1s, c2s, busy, done;
  logic [2:0]  st;
  logic [31:0] c1cyc, c2cyc;

  logic        layer4, c1s4, c2s4, busy4, done4;
  logic [2:0]  st4;
  logic [3:0]  c1cyc4, c2cyc4;

  int nchk = 0;
  int nerr = 0;

`ifdef GAT_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  gat_layer_sequencer #(.SWITCH_GAP(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_data_bram_load_done(ld_h),
    .h_node_info_bram_load_done(ld_n),
    .wgt_bram_load_done(ld_w),
    .gat_start(start), .gat_clr(clr),
    .conv1_done(c1d), .conv2_done(c2d),
    .gat_layer(layer), .conv1_start(c1s), .conv2_start(c2s),
    .gat_busy(busy), .gat_done(done), .gat_state(st),
    .conv1_cycles(c1cyc), .conv2_cycles(c2cyc)
  );

  gat_layer_sequencer #(.SWITCH_GAP(4), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .h_data_bram_load_done(ld_h),
    .h_node_info_bram_load_done(ld_n),
    .wgt_bram_load_done(ld_w),
    .gat_start(start), .gat_clr(clr),
    .conv1_done(c1d), .conv2_done(c2d),
    .gat_layer(layer4), .conv1_start(c1s4), .conv2_start(c2s4),
    .gat_busy(busy4), .gat_done(done4), .gat_state(st4),
    .conv1_cycles(c1cyc4), .conv2_cycles(c2cyc4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".state"}, 32'(st), 0);
    chk({tag, ".layer"}, 32'(layer), 0);
    chk({tag, ".c1s"},   32'(c1s), 0);
    chk({tag, ".c2s"},   32'(c2s), 0);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".done"},  32'(done), 0);
    chk({tag, ".c1cyc"}, c1cyc, 0);
    chk({tag, ".c2cyc"}, c2cyc, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {ld_h, ld_n, ld_w, start, clr, c1d, c2d} = '0;
    repeat (3) step();
    chk_reset("rst");
    rst_n = 1'b1;

    // Loads at cycles 2, 5, 9 with start held high
    start = 1'b1;
    step();
    ld_h = 1'b1; step(); ld_h = 1'b0;
    repeat (2) step();
    ld_n = 1'b1; step(); ld_n = 1'b0;
    repeat (3) step();
    chk("wait_loads.state", 32'(st), 0);
    ld_w = 1'b1; step(); ld_w = 1'b0;
    chk("start.state", 32'(st), 1);
    chk("start.c1s", 32'(c1s), 1);
    chk("start.busy", 32'(busy), 1);

    // Cycle S: conv1_done with conv1_start is ignored
    c1d = 1'b1; step(); c1d = 1'b0;
    chk("c1d_first.state", 32'(st), 1);
    chk("c1d_first.c1s", 32'(c1s), 0);
    // S+1: conv2_done in CONV1 ignored; S+2: clr ignored, start dropped
    c2d = 1'b1; step(); c2d = 1'b0;
    chk("c2d_in_c1.state", 32'(st), 1);
    clr = 1'b1; start = 1'b0; step(); clr = 1'b0;
    chk("clr_in_c1.state", 32'(st), 1);
    chk("clr_in_c1.layer", 32'(layer), 0);

    // Now at S+3; conv1_done at S+100
    repeat (97) step();
    c1d = 1'b1; step(); c1d = 1'b0;
    chk("gap1.state", 32'(st), 2);
    chk("gap1.layer", 32'(layer), 1);
    chk("gap1.busy", 32'(busy), 1);
    chk("c1cyc", c1cyc, PERF ? 100 : 0);
    chk("c1cyc4", 32'(c1cyc4), PERF ? 15 : 0);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk($sformatf("gap%0d.state", i), 32'(st), 2);
      chk($sformatf("gap%0d.c2s", i), 32'(c2s), 0);
    end
    step();
    chk("conv2.state", 32'(st), 3);
    chk("conv2.c2s", 32'(c2s), 1);
    chk("conv2.layer", 32'(layer), 1);

    // Cycle C: conv2_done with conv2_start ignored
    c2d = 1'b1; step(); c2d = 1'b0;
    chk("c2d_first.state", 32'(st), 3);
    chk("c2d_first.c2s", 32'(c2s), 0);
    c1d = 1'b1; step(); c1d = 1'b0;
    chk("c1d_in_c2.state", 32'(st), 3);
    // Now at C+2; conv2_done at C+40
    repeat (38) step();
    c2d = 1'b1; step(); c2d = 1'b0;
    chk("done.state", 32'(st), 4);
    chk("done.done", 32'(done), 1);
    chk("done.busy", 32'(busy), 0);
    chk("done.layer", 32'(layer), 1);
    chk("done.state4", 32'(st4), 4);
    chk("c2cyc", c2cyc, PERF ? 40 : 0);
    chk("c2cyc4", 32'(c2cyc4), PERF ? 15 : 0);
    repeat (3) step();
    chk("done_hold.state", 32'(st), 4);
    chk("c1cyc_hold", c1cyc, PERF ? 100 : 0);

    // Clear together with a fresh h_data load: the load must survive
    clr = 1'b1; ld_h = 1'b1; step(); clr = 1'b0; ld_h = 1'b0;
    chk("clr.state", 32'(st), 0);
    chk("clr.layer", 32'(layer), 0);
    chk("clr.done", 32'(done), 0);
    start = 1'b1;
    repeat (5) step();
    chk("no_reload.state", 32'(st), 0);
    ld_n = 1'b1; ld_w = 1'b1; step(); ld_n = 1'b0; ld_w = 1'b0;
    chk("set_wins.state", 32'(st), 1);
    chk("set_wins.c1s", 32'(c1s), 1);

    // Into GAP, then asynchronous reset mid-cycle
    step();
    c1d = 1'b1; step(); c1d = 1'b0;
    chk("gap_again.state", 32'(st), 2);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    step();
    rst_n = 1'b1;
    start = 1'b1;
    repeat (5) step();
    chk("post_rst.state", 32'(st), 0);
    chk("post_rst.busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/gat_layer_sequencer.md
GAT_LAYER_SEQUENCER -- requirements
Module: gat_layer_sequencer

Interface
REQ-001 SHALL have parameter SWITCH_GAP, default 4: idle cycles between conv1 completion and conv2 start; legal range 1..15.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done, input, 1 bit each: PS load-complete pulses or levels.
REQ-006 SHALL have port gat_start, input, 1 bit: level run request from PS.
REQ-007 SHALL have port gat_clr, input, 1 bit: pulse that acknowledges a finished run.
REQ-008 SHALL have ports conv1_done and conv2_done, input, 1 bit each: single-cycle layer-complete pulses.
REQ-009 SHALL have port gat_layer, output, 1 bit: layer select for the memory port muxes; 0 = conv1, 1 = conv2.
REQ-010 SHALL have ports conv1_start and conv2_start, output, 1 bit each: single-cycle start pulses.
REQ-011 SHALL have ports gat_busy and gat_done, output, 1 bit each; gat_state, output, 3 bits, current state encoding.
REQ-012 SHALL have ports conv1_cycles and conv2_cycles, output, CNT_WIDTH bits each: per-layer cycle counts.

Function
REQ-013 SHALL implement states IDLE=0, CONV1=1, GAP=2, CONV2=3, DONE=4.
REQ-014 SHALL latch each load_done input into a sticky flag, in any state.
REQ-015 IDLE->CONV1 SHALL occur when all three flags are set and gat_start=1.
REQ-016 conv1_start SHALL be high exactly during the first cycle in CONV1; conv2_start SHALL be high exactly during the first cycle in CONV2. Both SHALL be registered outputs.
REQ-017 conv1_done SHALL be honoured only in CONV1 and not in its first cycle. Otherwise it SHALL be ignored; conv2_done follows the same rule for CONV2.
REQ-018 CONV1->GAP on an honoured conv1_done. gat_layer SHALL go to 1 in the first GAP cycle and hold until IDLE.
REQ-019 GAP SHALL last exactly SWITCH_GAP cycles, using a down-counter loaded with SWITCH_GAP-1 that moves to CONV2 at 0.
REQ-020 CONV2->DONE on an honoured conv2_done.
REQ-021 gat_done SHALL be 1 exactly while in DONE.
REQ-022 gat_busy SHALL be 1 in CONV1, GAP and CONV2.
REQ-023 DONE->IDLE on gat_clr=1. On that transition SHALL clear the three load flags and set gat_layer=0.
REQ-024 gat_clr outside DONE SHALL be ignored.
REQ-025 If a load_done is set in the same cycle as the gat_clr clear, set SHALL win.
REQ-026 Deasserting gat_start after leaving IDLE SHALL NOT abort the run.

Reset
REQ-027 On rst_n=0, the block SHALL asynchronously enter IDLE and clear all flags and counters.
REQ-028 Reset values SHALL be: gat_layer=0, conv1_start=0, conv2_start=0, gat_busy=0, gat_done=0, gat_state=0, conv1_cycles=0, conv2_cycles=0.
REQ-029 Reset mid-run SHALL abandon the run; a new run requires fresh load_done events.

Configuration
REQ-030 With macro GAT_SEQ_PERF_CNT_EN defined:
- conv1_cycles SHALL clear on entering CONV1 and increment every cycle in CONV1.
- conv2_cycles SHALL behave the same for CONV2.
- Both SHALL saturate at all-ones and hold their value until the next run's start.
REQ-031 Without GAT_SEQ_PERF_CNT_EN, conv1_cycles and conv2_cycles SHALL be constant 0 with no counter logic; the ports SHALL remain.

Structure
REQ-032 The state enum typedef, the state encodings and the SWITCH_GAP legal bounds SHALL live in the shared package gat_pkg.
REQ-033 The saturating counter SHALL be a sub-module gat_sat_counter (enable, clear, saturate), instantiated twice under the macro.

Verification
REQ-034 Loads and start: pulse the three load_done inputs at cycles 2, 5 and 9 with gat_start=1 -> conv1_start pulses in the cycle after cycle 9; gat_state=1.
REQ-035 Layer switch: with SWITCH_GAP=4, conv1_done -> gat_layer=1 next cycle; conv2_start exactly 4 cycles later.
REQ-036 Ignored done pulses:
- conv1_done coincident with conv1_start -> ignored, state stays CONV1.
- conv2_done while in CONV1 -> ignored.
REQ-037 Completion and clear: conv2_done -> gat_done=1; gat_clr -> IDLE with gat_layer=0. A second gat_start without new loads -> stays in IDLE.
REQ-038 Performance counters (macro on): conv1_done arrives 100 cycles after conv1_start -> conv1_cycles=100. With CNT_WIDTH=4 and a 40-cycle CONV2 -> conv2_cycles=15.
REQ-039 Reset mid-run: drive rst_n=0 in GAP -> all outputs at reset values immediately; after release, gat_start=1 -> stays in IDLE.
